// File: rtl/half_adder_sync.sv
// half_adder_sync: registered, multi-lane half adder.
// Each lane i computes sum[i] = a[i] ^ b[i] and carry[i] = a[i] & b[i].
// The result and a single out_valid flag are registered, so latency is one cycle.
// Lanes are fully independent: there is no carry propagation between them.
// Optional feature macro: HALF_ADDER_SYNC_STATS_EN. When it is defined, the
// saturating op_count and carry_count statistics ports and registers exist.
// When it is undefined, both are removed entirely.
module half_adder_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
`ifdef HALF_ADDER_SYNC_STATS_EN
    output logic [15:0]      op_count,
    output logic [15:0]      carry_count,
`endif
    output logic             out_valid
);

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    logic [WIDTH-1:0] lane_sum;
    logic [WIDTH-1:0] lane_carry;
    logic             any_carry;

    // Per-lane half-adder math on the raw operands; registered below only on accept.
    always_comb begin
        lane_sum   = a ^ b;
        lane_carry = a & b;
        any_carry  = |lane_carry;
    end

    // Result registers: load on accept, otherwise hold so idle-cycle operands never reach the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum   <= '0;
            carry <= '0;
        end else if (in_valid) begin
            sum   <= lane_sum;
            carry <= lane_carry;
        end
    end

    // Valid flag follows accepted inputs by exactly one cycle; reset discards an accept in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

`ifdef HALF_ADDER_SYNC_STATS_EN
    // Saturating count of accepted operations.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (in_valid && (op_count != COUNT_MAX)) begin
            op_count <= op_count + 16'd1;
        end
    end

    // Saturating count of accepted operations in which at least one lane produced a carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_count <= '0;
        end else if (in_valid && any_carry && (carry_count != COUNT_MAX)) begin
            carry_count <= carry_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_half_adder_sync.sv
// Testbench for half_adder_sync (WIDTH=8).
// The stimulus side pushes expected post-edge state into a scoreboard queue;
// an independent monitor pops and compares one entry after every rising edge.
// The statistics checks are compiled only when HALF_ADDER_SYNC_STATS_EN is defined.
module tb_half_adder_sync;

    localparam int W = 8;

    typedef struct packed {
        logic         valid;
        logic [W-1:0] sum;
        logic [W-1:0] carry;
        logic [15:0]  ops;
        logic [15:0]  carries;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic [W-1:0] carry;
    logic         out_valid;
`ifdef HALF_ADDER_SYNC_STATS_EN
    logic [15:0]  op_count;
    logic [15:0]  carry_count;
`endif

    exp_t exp_q[$];
    int   checks;
    int   errors;

    // Reference model state: what the outputs must show after the next edge.
    logic [W-1:0] m_sum;
    logic [W-1:0] m_carry;
    int           m_ops;
    int           m_carries;

    half_adder_sync #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .sum        (sum),
        .carry      (carry),
`ifdef HALF_ADDER_SYNC_STATS_EN
        .op_count   (op_count),
        .carry_count(carry_count),
`endif
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, update the model from the arithmetic rules, push the expectation.
    task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        int   lane_total;
        rst_n    = r;
        in_valid = v;
        a        = av;
        b        = bv;
        if (!r) begin
            m_sum = '0; m_carry = '0; m_ops = 0; m_carries = 0;
            e.valid = 1'b0;
        end else if (v) begin
            for (int i = 0; i < W; i++) begin
                lane_total = int'(av[i]) + int'(bv[i]);
                m_sum[i]   = (lane_total % 2) == 1;
                m_carry[i] = (lane_total / 2) == 1;
            end
            if (m_ops < 65535) m_ops++;
            if (m_carry != 0 && m_carries < 65535) m_carries++;
            e.valid = 1'b1;
        end else begin
            e.valid = 1'b0;
        end
        e.sum     = m_sum;
        e.carry   = m_carry;
        e.ops     = 16'(m_ops);
        e.carries = 16'(m_carries);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: after each rising edge, pop one expectation and compare the registered outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard_empty: got no expectation, required one at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                checkOutput("out_valid", 64'(out_valid), 64'(e.valid));
                checkOutput("sum", 64'(sum), 64'(e.sum));
                checkOutput("carry", 64'(carry), 64'(e.carry));
`ifdef HALF_ADDER_SYNC_STATS_EN
                checkOutput("op_count", 64'(op_count), 64'(e.ops));
                checkOutput("carry_count", 64'(carry_count), 64'(e.carries));
`endif
            end
        end
    end

    initial begin
        logic [W-1:0] xv;
        checks = 0; errors = 0;
        m_sum = '0; m_carry = '0; m_ops = 0; m_carries = 0;

        // Reset.
        applyStimulus(1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b0, '0, '0);

        // Exhaustive lane-0 truth table, back to back.
        applyStimulus(1'b1, 1'b1, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h00, 8'h01);
        applyStimulus(1'b1, 1'b1, 8'h01, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h01, 8'h01);

        // Hold: accept 11 then idle three cycles with zero operands.
        applyStimulus(1'b1, 1'b1, 8'h01, 8'h01);
        repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);

        // Reset priority over in_valid, then first accept after release.
        applyStimulus(1'b0, 1'b1, 8'h01, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h01, 8'h00);

        // Lane independence.
        applyStimulus(1'b1, 1'b1, 8'hF0, 8'hCC);
        applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF);
        applyStimulus(1'b1, 1'b1, 8'hAA, 8'h55);

        // Unknown operands while idle must not disturb held outputs.
        xv = 'x;
        applyStimulus(1'b1, 1'b0, xv, xv);
        applyStimulus(1'b1, 1'b0, xv, 8'h3C);

        // Reset mid-stream.
        applyStimulus(1'b1, 1'b1, 8'h0F, 8'h0F);
        applyStimulus(1'b0, 1'b1, 8'hFF, 8'hFF);
        applyStimulus(1'b1, 1'b0, 8'hFF, 8'hFF);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) < 7),
                          W'($urandom), W'($urandom));
        end

`ifdef HALF_ADDER_SYNC_STATS_EN
        // Statistics: 5 accepts (2 with a carry) plus 3 idle cycles.
        applyStimulus(1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b1, 8'h01, 8'h01);
        applyStimulus(1'b1, 1'b0, 8'hFF, 8'hFF);
        applyStimulus(1'b1, 1'b1, 8'h01, 8'h02);
        applyStimulus(1'b1, 1'b1, 8'h80, 8'h80);
        applyStimulus(1'b1, 1'b0, 8'hFF, 8'hFF);
        applyStimulus(1'b1, 1'b1, 8'h0F, 8'hF0);
        applyStimulus(1'b1, 1'b0, 8'hFF, 8'hFF);
        applyStimulus(1'b1, 1'b1, 8'h00, 8'h00);

        // Saturation of both counters.
        applyStimulus(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 65540; i++) applyStimulus(1'b1, 1'b1, 8'h01, 8'h01);
        applyStimulus(1'b1, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b1, 8'h01, 8'h00);
`endif

        applyStimulus(1'b1, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
